// File: rtl/csr_access_arbiter_if.sv
// Bundle of core, host and CSR-bank signals shared through csr_access_arbiter.
// The arbiter uses the slave modport; the requester/bank side uses the master modport.
interface csr_access_arbiter_if;
    logic        core_csr_enable;
    logic [11:0] core_csr_addr;
    logic [2:0]  core_csr_op;
    logic [4:0]  core_rs1_zimm;
    logic [31:0] core_rs1_data;
    logic        core_stall;
    logic        host_req_valid;
    logic        host_req_ready;
    logic [11:0] host_addr;
    logic        host_we;
    logic [31:0] host_wdata;
    logic        host_rsp_valid;
    logic        host_rsp_ready;
    logic [31:0] host_rsp_data;
    logic        csr_enable;
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic [4:0]  csr_rs1_zimm;
    logic [31:0] csr_rs1_data;
    logic [31:0] csr_rdata;
    logic [15:0] stall_count;

    modport slave (
        input  core_csr_enable, core_csr_addr, core_csr_op, core_rs1_zimm, core_rs1_data,
        input  host_req_valid, host_addr, host_we, host_wdata, host_rsp_ready, csr_rdata,
        output core_stall, host_req_ready, host_rsp_valid, host_rsp_data,
        output csr_enable, csr_addr, csr_op, csr_rs1_zimm, csr_rs1_data, stall_count
    );

    modport master (
        output core_csr_enable, core_csr_addr, core_csr_op, core_rs1_zimm, core_rs1_data,
        output host_req_valid, host_addr, host_we, host_wdata, host_rsp_ready, csr_rdata,
        input  core_stall, host_req_ready, host_rsp_valid, host_rsp_data,
        input  csr_enable, csr_addr, csr_op, csr_rs1_zimm, csr_rs1_data, stall_count
    );
endinterface

// File: rtl/csr_access_arbiter.sv
// Shares the CSR access bus between the core (priority) and a host port with bounded wait.
// Optional stall statistics counter enabled by defining CSR_ARB_STALL_STATS_EN.
module csr_access_arbiter #(
    parameter int MaxWait = 4,
    parameter int WaitW   = (MaxWait < 1) ? 1 : $clog2(MaxWait + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    csr_access_arbiter_if.slave  bus
);
    localparam logic [2:0]       CSRRW   = 3'b001;
    localparam logic [WaitW-1:0] MAX_CNT = WaitW'(MaxWait);

    typedef enum logic {IDLE, RSP} state_t;

    state_t            state_reg, state_next;
    logic [WaitW-1:0]  wait_reg, wait_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [31:0]       rsp_data_reg, rsp_data_next;
    logic              host_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            wait_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            wait_reg      <= wait_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_next      = wait_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        host_grant     = 1'b0;

        bus.csr_enable   = bus.core_csr_enable;
        bus.csr_addr     = bus.core_csr_addr;
        bus.csr_op       = bus.core_csr_op;
        bus.csr_rs1_zimm = bus.core_rs1_zimm;
        bus.csr_rs1_data = bus.core_rs1_data;
        bus.core_stall     = 1'b0;
        bus.host_req_ready = 1'b0;

        case (state_reg)
            IDLE: begin
                host_grant = bus.host_req_valid &&
                             (!bus.core_csr_enable || wait_reg == MAX_CNT);
                if (host_grant) begin
                    bus.host_req_ready = 1'b1;
                    bus.core_stall     = bus.core_csr_enable;
                    bus.csr_enable     = bus.host_we;
                    bus.csr_addr       = bus.host_addr;
                    bus.csr_op         = CSRRW;
                    bus.csr_rs1_zimm   = 5'd0;
                    bus.csr_rs1_data   = bus.host_wdata;
                    // Capture the pre-write value; the write lands at this same edge.
                    rsp_data_next      = bus.csr_rdata;
                    rsp_valid_next     = 1'b1;
                    wait_next          = '0;
                    state_next         = RSP;
                end else if (!bus.host_req_valid) begin
                    wait_next = '0;
                end else if (bus.core_csr_enable && wait_reg != MAX_CNT) begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            RSP: begin
                if (!bus.host_req_valid) begin
                    wait_next = '0;
                end
                if (bus.host_rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.host_rsp_valid = rsp_valid_reg;
    assign bus.host_rsp_data  = rsp_data_reg;

`ifdef CSR_ARB_STALL_STATS_EN
    logic [15:0] stall_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_reg <= '0;
        end else if (bus.core_stall && stall_count_reg != 16'hFFFF) begin
            stall_count_reg <= stall_count_reg + 16'd1;
        end
    end

    assign bus.stall_count = stall_count_reg;
`else
    assign bus.stall_count = 16'd0;
`endif
endmodule
